pu_compare_chain: RTL and testbench
===================================

# pu_compare_chain

Parametrised comparison processing unit: the next generation of the two-argument compare PU. It accepts a stream of ARG_COUNT arguments per operation and evaluates a chained relation (e.g. a0 < a1 < a2) or a MIN/MAX reduction, in signed or unsigned mode. Results queue in a small result FIFO drained by `oe`. Invalid inputs, invalid opcodes, empty reads and dropped results are reported through attribute bits. It sits on the standard PU data/attr bus alongside the other processing units.

## Interface
- DATA_WIDTH, 32, argument/result width
- ATTR_WIDTH, 4, attribute bus width (≥2)
- SEL_WIDTH, 4, op_sel width; bit 3 = unsigned mode, bits 2:0 = opcode
- ARG_COUNT, 2, arguments per operation (≥2)
- FIFO_DEPTH, 4, result FIFO entries (power of 2, ≥2)
- clk  in  1  clock; everything on posedge
- rst  in  1  reset; one clock, asynchronous, active-high
- wr  in  1  argument write strobe
- oe  in  1  result read/pop strobe
- data_in  in  DATA_WIDTH  argument
- attr_in  in  ATTR_WIDTH  argument attributes; bit INVALID (0) marks a bad argument
- op_sel  in  SEL_WIDTH  operation; sampled only with the first argument
- data_out  out  DATA_WIDTH  FIFO head when oe, else 0
- attr_out  out  ATTR_WIDTH  bit 0 INVALID, bit 1 OVERFLOW, other bits 0; all 0 when oe low

## Operation
- Opcodes: EQ=0, LT=1, LTE=2, GT=3, GTE=4, MIN=5, MAX=6; 7 is illegal.
- Comparison is signed unless op_sel[3]=1, in which case it is unsigned.
- FSM is ST_IDLE/ST_COLLECT with arg_cnt 0..ARG_COUNT-1.
- wr in ST_IDLE:
  - latch op and mode; prev←data_in, acc_val←data_in, acc_bool←1, inv←attr_in[0]
  - if ARG_COUNT>1, go to ST_COLLECT with arg_cnt=1
- wr in ST_COLLECT:
  - acc_bool &= rel(prev, data_in); acc_val←min/max(acc_val, data_in); prev←data_in; inv |= attr_in[0]
  - arg_cnt increments
- On the wr that delivers argument ARG_COUNT-1:
  - push result, return to ST_IDLE, arg_cnt←0
  - compare ops push zero-extended acc_bool (0 or 1); MIN/MAX push acc_val
  - the entry INVALID flag is set if inv is set or the opcode is illegal
  - an illegal opcode pushes data 0
- The final update and the push happen on the same edge; partial state is not stored separately.
- The FIFO stores {invalid, data} per entry. The oe cycle presents the head combinationally and pops it on the edge.
- oe with the FIFO empty: data_out=0, attr_out[INVALID]=1, no pop.
- Push with the FIFO full and no simultaneous pop: the result is dropped and the sticky overflow flag is set.
  - overflow appears on attr_out[OVERFLOW] during the next oe cycle, then clears on that edge.
- Simultaneous wr (final) and oe:
  - full: pop and push both succeed, no overflow
  - empty: the read reports empty/INVALID and the push is stored
- op_sel is ignored on non-first writes. An opcode change mid-operation has no effect.
- Reset at any time:
  - discards partial arguments
  - flushes the FIFO
  - clears overflow
  - returns to ST_IDLE

## Timing
- Reset values: state ST_IDLE, arg_cnt 0, FIFO empty, overflow 0, data_out 0, attr_out 0.
- Latency: a result is readable via oe in the cycle after the edge that samples the final wr. There is no combinational path from wr to data_out.
- Throughput: one argument per cycle. Back-to-back operations need no idle cycle.
- data_out and attr_out are combinational from FIFO head, oe and flags; there is no output register.
- With ARG_COUNT=2 the externally visible behaviour matches the previous compare PU, apart from the FIFO and flags.

## Structure
- Package pu_compare_pkg holds:
  - opcode constants
  - the unsigned-mode bit index
  - attr bit indices INVALID=0 and OVERFLOW=1
  - state encodings
- Sub-module pu_compare_fifo: synchronous FIFO with async reset, width DATA_WIDTH+1, depth FIFO_DEPTH, ports push/pop/full/empty/head. Simultaneous push+pop when full is allowed.
- Top level holds the FSM, accumulators, relation/min-max logic and the overflow flag.

## Test plan
- ARG_COUNT=2, signed LT, args -5 then 3 → next cycle oe: data_out=1, attr_out=0; same with op_sel[3]=1 (unsigned) → data_out=0.
- ARG_COUNT=3, LT, args 1,2,2 → 0; LTE, args 1,2,2 → 1; MAX, args 7,-2,9 → 9; MIN unsigned, args 5, 0xFFFFFFFF, 3 → 3.
- ARG_COUNT=2: 5 operations with no reads (FIFO_DEPTH=4) → 4 reads return the first 4 results, OVERFLOW set only on the first read; a 5th read gives data 0 with INVALID.
- Second argument has attr_in[0]=1 → result INVALID set. Opcode 7 → data 0, INVALID. oe with FIFO empty → 0 with INVALID.
- FIFO full, final wr and oe in the same cycle → head popped, new result stored, no OVERFLOW; 4 subsequent reads in order.
- ARG_COUNT=3: rst asserted after 2 arguments mid-cycle (async) → FIFO empty, state idle; the next 3 args form a fresh, correct result.

Source files
------------

// File: rtl/pu_compare_pkg.sv
// Shared constants and types for the chained compare processing unit.
package pu_compare_pkg;

    localparam logic [2:0] OP_EQ  = 3'd0;
    localparam logic [2:0] OP_LT  = 3'd1;
    localparam logic [2:0] OP_LTE = 3'd2;
    localparam logic [2:0] OP_GT  = 3'd3;
    localparam logic [2:0] OP_GTE = 3'd4;
    localparam logic [2:0] OP_MIN = 3'd5;
    localparam logic [2:0] OP_MAX = 3'd6;
    localparam logic [2:0] OP_ILL = 3'd7;

    localparam int unsigned UNS_BIT       = 3;
    localparam int unsigned ATTR_INVALID  = 0;
    localparam int unsigned ATTR_OVERFLOW = 1;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    // True for the reduction opcodes, which deliver a value rather than a flag.
    function automatic logic is_minmax(input logic [2:0] op);
        return (op == OP_MIN) || (op == OP_MAX);
    endfunction

endpackage

// File: rtl/pu_compare_chain_if.sv
// PU data/attr bus: argument stream in, FIFO read port out.
interface pu_compare_chain_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ATTR_WIDTH = 4,
    parameter int unsigned SEL_WIDTH  = 4
) ();
    logic                  wr;
    logic                  oe;
    logic [DATA_WIDTH-1:0] data_in;
    logic [ATTR_WIDTH-1:0] attr_in;
    logic [SEL_WIDTH-1:0]  op_sel;
    logic [DATA_WIDTH-1:0] data_out;
    logic [ATTR_WIDTH-1:0] attr_out;

    modport master (
        output wr, oe, data_in, attr_in, op_sel,
        input  data_out, attr_out
    );

    modport slave (
        input  wr, oe, data_in, attr_in, op_sel,
        output data_out, attr_out
    );
endinterface

// File: rtl/pu_compare_fifo.sv
// Result FIFO; a push while full is accepted when a pop happens on the same edge.
module pu_compare_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             wr_en;
    logic             rd_en;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head_o  = mem[rptr_q[AW-1:0]];
    assign rd_en   = pop_i && !empty_o;
    assign wr_en   = push_i && (!full_o || rd_en);

    // Pointer advance.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_en) wptr_d = (AW+1)'(wptr_q + 1'b1);
        if (rd_en) rptr_d = (AW+1)'(rptr_q + 1'b1);
    end

    // Pointer registers; reset flushes the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage write; contents are don't-care until a pointer covers them.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/pu_compare_chain.sv
// Chained relation / min-max reduction over ARG_COUNT streamed arguments.
module pu_compare_chain
    import pu_compare_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ATTR_WIDTH = 4,
    parameter int unsigned SEL_WIDTH  = 4,
    parameter int unsigned ARG_COUNT  = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    pu_compare_chain_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(ARG_COUNT);
    localparam int unsigned ENT_W = DATA_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ARG_COUNT - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            op_q, op_d;
    logic                  uns_q, uns_d;
    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic [DATA_WIDTH-1:0] acc_val_q, acc_val_d;
    logic                  acc_bool_q, acc_bool_d;
    logic                  inv_q, inv_d;
    logic                  overflow_q, overflow_d;

    logic                  push_c;
    logic [ENT_W-1:0]      push_ent_c;
    logic                  rel_c;
    logic                  mm_lt_c;
    logic [DATA_WIDTH-1:0] mm_val_c;
    logic                  bool_nx_c;
    logic                  inv_nx_c;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENT_W-1:0]      fifo_head;
    logic                  fifo_pop;
    logic                  drop_c;
    logic                  unused_c;

    assign unused_c = ^{bus.attr_in, bus.op_sel};

    // a < b in the latched signedness mode.
    function automatic logic less_f(input logic uns, input logic [DATA_WIDTH-1:0] a,
                                    input logic [DATA_WIDTH-1:0] b);
        return uns ? (a < b) : ($signed(a) < $signed(b));
    endfunction

    // Relation between the previous and the incoming argument.
    always_comb begin
        logic lt;
        logic eq;
        lt    = less_f(uns_q, prev_q, bus.data_in);
        eq    = (prev_q == bus.data_in);
        rel_c = 1'b0;
        case (op_q)
            OP_EQ:   rel_c = eq;
            OP_LT:   rel_c = lt;
            OP_LTE:  rel_c = lt | eq;
            OP_GT:   rel_c = !(lt | eq);
            OP_GTE:  rel_c = !lt;
            default: rel_c = 1'b0;
        endcase
    end

    // Running min/max and the merged partial results for this write.
    always_comb begin
        mm_lt_c   = less_f(uns_q, acc_val_q, bus.data_in);
        mm_val_c  = acc_val_q;
        if (op_q == OP_MAX && mm_lt_c)  mm_val_c = bus.data_in;
        if (op_q == OP_MIN && !mm_lt_c) mm_val_c = bus.data_in;
        bool_nx_c = acc_bool_q & rel_c;
        inv_nx_c  = inv_q | bus.attr_in[ATTR_INVALID];
    end

    // Argument collection FSM; the final argument pushes straight into the FIFO.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        uns_d      = uns_q;
        prev_d     = prev_q;
        acc_val_d  = acc_val_q;
        acc_bool_d = acc_bool_q;
        inv_d      = inv_q;
        push_c     = 1'b0;
        push_ent_c = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.wr) begin
                    op_d       = bus.op_sel[2:0];
                    uns_d      = bus.op_sel[UNS_BIT];
                    prev_d     = bus.data_in;
                    acc_val_d  = bus.data_in;
                    acc_bool_d = 1'b1;
                    inv_d      = bus.attr_in[ATTR_INVALID];
                    state_d    = ST_COLLECT;
                    cnt_d      = CNT_W'(1);
                end
            end
            ST_COLLECT: begin
                if (bus.wr) begin
                    acc_bool_d = bool_nx_c;
                    acc_val_d  = mm_val_c;
                    prev_d     = bus.data_in;
                    inv_d      = inv_nx_c;
                    cnt_d      = CNT_W'(cnt_q + 1'b1);
                    if (cnt_q == LAST_CNT) begin
                        push_c  = 1'b1;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        if (op_q == OP_ILL)
                            push_ent_c = {1'b1, {DATA_WIDTH{1'b0}}};
                        else if (is_minmax(op_q))
                            push_ent_c = {inv_nx_c, mm_val_c};
                        else
                            push_ent_c = {inv_nx_c, DATA_WIDTH'(bool_nx_c)};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pop on a read of a non-empty FIFO; a full push without a pop is lost.
    always_comb begin
        fifo_pop   = bus.oe && !fifo_empty;
        drop_c     = push_c && fifo_full && !fifo_pop;
        overflow_d = bus.oe ? 1'b0 : overflow_q;
        if (drop_c) overflow_d = 1'b1;
    end

    // State and accumulator registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            uns_q      <= 1'b0;
            prev_q     <= '0;
            acc_val_q  <= '0;
            acc_bool_q <= 1'b0;
            inv_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            uns_q      <= uns_d;
            prev_q     <= prev_d;
            acc_val_q  <= acc_val_d;
            acc_bool_q <= acc_bool_d;
            inv_q      <= inv_d;
            overflow_q <= overflow_d;
        end
    end

    pu_compare_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_c),
        .pop_i   (fifo_pop),
        .din_i   (push_ent_c),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    // Read port: head while oe, empty reads flagged invalid, zeros otherwise.
    always_comb begin
        bus.data_out = '0;
        bus.attr_out = '0;
        if (bus.oe) begin
            if (!fifo_empty) bus.data_out = fifo_head[DATA_WIDTH-1:0];
            bus.attr_out[ATTR_INVALID]  = fifo_empty | fifo_head[DATA_WIDTH];
            bus.attr_out[ATTR_OVERFLOW] = overflow_q;
        end
    end
endmodule

// File: tb/tb_pu_compare_chain.sv
// Scoreboard bench for pu_compare_chain with ARG_COUNT=2 and ARG_COUNT=3 instances.
module tb_pu_compare_chain;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  a;
    } exp_t;

    logic clk = 1'b0;
    logic rst2 = 1'b1;
    logic rst3 = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q2[$];
    exp_t q3[$];
    exp_t e2;
    exp_t e3;

    pu_compare_chain_if #(.DATA_WIDTH(32), .ATTR_WIDTH(4), .SEL_WIDTH(4)) if2 ();
    pu_compare_chain_if #(.DATA_WIDTH(32), .ATTR_WIDTH(4), .SEL_WIDTH(4)) if3 ();

    pu_compare_chain #(.DATA_WIDTH(32), .ATTR_WIDTH(4), .SEL_WIDTH(4),
                       .ARG_COUNT(2), .FIFO_DEPTH(4)) dut2 (
        .clk (clk), .rst (rst2), .bus (if2)
    );
    pu_compare_chain #(.DATA_WIDTH(32), .ATTR_WIDTH(4), .SEL_WIDTH(4),
                       .ARG_COUNT(3), .FIFO_DEPTH(4)) dut3 (
        .clk (clk), .rst (rst3), .bus (if3)
    );

    always #5 clk = ~clk;

    // One cycle on the ARG_COUNT=2 unit; a read queues its expected response.
    task automatic cyc2(input logic w, input logic o, input logic [31:0] d,
                        input logic [3:0] a, input logic [3:0] s,
                        input logic [31:0] ed, input logic [3:0] ea);
        exp_t e;
        if2.wr = w; if2.oe = o; if2.data_in = d; if2.attr_in = a; if2.op_sel = s;
        if (o) begin e.d = ed; e.a = ea; q2.push_back(e); end
        @(posedge clk); #1;
        if2.wr = 1'b0; if2.oe = 1'b0;
    endtask

    task automatic cyc3(input logic w, input logic o, input logic [31:0] d,
                        input logic [3:0] a, input logic [3:0] s,
                        input logic [31:0] ed, input logic [3:0] ea);
        exp_t e;
        if3.wr = w; if3.oe = o; if3.data_in = d; if3.attr_in = a; if3.op_sel = s;
        if (o) begin e.d = ed; e.a = ea; q3.push_back(e); end
        @(posedge clk); #1;
        if3.wr = 1'b0; if3.oe = 1'b0;
    endtask

    task automatic w2(input logic [31:0] d, input logic [3:0] s);
        cyc2(1'b1, 1'b0, d, 4'h0, s, 32'h0, 4'h0);
    endtask
    task automatic r2(input logic [31:0] ed, input logic [3:0] ea);
        cyc2(1'b0, 1'b1, 32'h0, 4'h0, 4'h0, ed, ea);
    endtask
    task automatic w3(input logic [31:0] d, input logic [3:0] s);
        cyc3(1'b1, 1'b0, d, 4'h0, s, 32'h0, 4'h0);
    endtask
    task automatic r3(input logic [31:0] ed, input logic [3:0] ea);
        cyc3(0, 1'b1, 32'h0, 4'h0, 4'h0, ed, ea);
    endtask

    task automatic chk(input string nm, input logic [35:0] got, input logic [35:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Monitor for the ARG_COUNT=2 unit.
    always @(negedge clk) begin
        if (if2.oe) begin
            n_cmp++;
            if (q2.size() == 0) begin
                n_err++;
                $display("FAIL dut2 read: no expected entry, got data=%h attr=%h",
                         if2.data_out, if2.attr_out);
            end else begin
                e2 = q2.pop_front();
                if (if2.data_out !== e2.d || if2.attr_out !== e2.a) begin
                    n_err++;
                    $display("FAIL dut2 read @%0t: got data=%h attr=%h want data=%h attr=%h",
                             $time, if2.data_out, if2.attr_out, e2.d, e2.a);
                end
            end
        end
    end

    // Monitor for the ARG_COUNT=3 unit.
    always @(negedge clk) begin
        if (if3.oe) begin
            n_cmp++;
            if (q3.size() == 0) begin
                n_err++;
                $display("FAIL dut3 read: no expected entry, got data=%h attr=%h",
                         if3.data_out, if3.attr_out);
            end else begin
                e3 = q3.pop_front();
                if (if3.data_out !== e3.d || if3.attr_out !== e3.a) begin
                    n_err++;
                    $display("FAIL dut3 read @%0t: got data=%h attr=%h want data=%h attr=%h",
                             $time, if3.data_out, if3.attr_out, e3.d, e3.a);
                end
            end
        end
    end

    initial begin
        if2.wr = 0; if2.oe = 0; if2.data_in = 0; if2.attr_in = 0; if2.op_sel = 0;
        if3.wr = 0; if3.oe = 0; if3.data_in = 0; if3.attr_in = 0; if3.op_sel = 0;
        repeat (2) @(posedge clk);
        #1; rst2 = 1'b0; rst3 = 1'b0;
        @(negedge clk);
        chk("reset dut2", {if2.attr_out, if2.data_out}, 36'h0);
        chk("reset dut3", {if3.attr_out, if3.data_out}, 36'h0);
        @(posedge clk); #1;

        // ---- ARG_COUNT=2 ----
        w2(-32'sd5, 4'd1); w2(32'd3, 4'd1); r2(32'd1, 4'h0);          // signed LT
        w2(-32'sd5, 4'd9); w2(32'd3, 4'd9); r2(32'd0, 4'h0);          // unsigned LT

        // Five results, no reads: fifth dropped; second arg's op_sel is ignored.
        w2(32'd4, 4'd0);  w2(32'd4, 4'd0);                            // EQ -> 1
        w2(32'd9, 4'd3);  w2(32'd2, 4'd7);                            // GT -> 1
        w2(32'd2, 4'd4);  w2(32'd9, 4'd4);                            // GTE -> 0
        w2(32'd10, 4'd5); w2(-32'sd3, 4'd5);                          // MIN -> -3
        w2(32'd10, 4'd6); w2(-32'sd3, 4'd6);                          // MAX -> dropped
        r2(32'd1, 4'h2);
        r2(32'd1, 4'h0);
        r2(32'd0, 4'h0);
        r2(32'hFFFF_FFFD, 4'h0);
        r2(32'd0, 4'h1);

        // Invalid argument, illegal opcode, empty read.
        w2(32'd1, 4'd1); cyc2(1'b1, 1'b0, 32'd2, 4'h1, 4'd1, 32'h0, 4'h0);
        r2(32'd1, 4'h1);
        w2(32'd3, 4'd7); w2(32'd3, 4'd7); r2(32'd0, 4'h1);
        r2(32'd0, 4'h1);

        // Full FIFO with final write and read on the same edge.
        w2(32'd1, 4'd0); w2(32'd1, 4'd0);                             // 1
        w2(32'd1, 4'd0); w2(32'd2, 4'd0);                             // 0
        w2(32'd2, 4'd1); w2(32'd3, 4'd1);                             // 1
        w2(32'd5, 4'd6); w2(32'd6, 4'd6);                             // 6
        w2(32'd8, 4'd5);
        cyc2(1'b1, 1'b1, 32'd4, 4'h0, 4'd5, 32'd1, 4'h0);             // MIN -> 4
        r2(32'd0, 4'h0);
        r2(32'd1, 4'h0);
        r2(32'd6, 4'h0);
        r2(32'd4, 4'h0);
        r2(32'd0, 4'h1);

        // ---- ARG_COUNT=3, back-to-back operations ----
        w3(32'd1, 4'd1); w3(32'd2, 4'd1); w3(32'd2, 4'd1);            // LT -> 0
        w3(32'd1, 4'd2); w3(32'd2, 4'd2); w3(32'd2, 4'd2);            // LTE -> 1
        w3(32'd7, 4'd6); w3(-32'sd2, 4'd6); w3(32'd9, 4'd6);          // MAX -> 9
        w3(32'd5, 4'd13); w3(32'hFFFF_FFFF, 4'd13); w3(32'd3, 4'd13); // MIN uns -> 3
        r3(32'd0, 4'h0);
        r3(32'd1, 4'h0);
        r3(32'd9, 4'h0);
        r3(32'd3, 4'h0);

        // Async reset mid-operation with a result already queued.
        w3(32'd5, 4'd0); w3(32'd5, 4'd0); w3(32'd5, 4'd0);            // EQ -> 1, unread
        w3(32'd1, 4'd1); w3(32'd2, 4'd1);
        #2 rst3 = 1'b1;
        #1 chk("dut3 in reset", {if3.attr_out, if3.data_out}, 36'h0);
        @(posedge clk); #1 rst3 = 1'b0;
        r3(32'd0, 4'h1);
        w3(32'd9, 4'd3); w3(32'd5, 4'd3); w3(32'd1, 4'd3);            // GT -> 1
        r3(32'd1, 4'h0);

        repeat (2) @(posedge clk);
        chk("dut2 queue drained", 36'(q2.size()), 36'h0);
        chk("dut3 queue drained", 36'(q3.size()), 36'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
